overlay_sequencer: RTL and testbench
====================================

// Module: overlay_sequencer
// PURPOSE
//  Game-flow controller for the on-screen text overlay. It decides which text layer is
//  shown (LEVEL n banner, WIN!, GAME OVER) and when, and it blinks end-of-game text.
//  It gates maze play via game_active and tracks the current level index.
//  Sits between the game logic (death/goal events, start button) and the VGA colour mux;
//  it consumes the per-pixel text masks produced by the text renderer.
// PARAMETERS
//  BANNER_FRAMES    120  frames the "LEVEL n" banner is held before play starts
//  BLINK_FRAMES      30  frames per blink half-period for WIN!/GAME OVER
//  END_HOLD_FRAMES  180  minimum frames on an end screen before start_btn is accepted
//  NUM_LEVELS         2  number of levels; level_idx wraps to 0 only via restart
// PORTS
//  clk              in   1  pixel clock; single clock domain
//  rst              in   1  synchronous, active-high reset
//  frame_tick       in   1  one-clk pulse per frame (start of vertical blank)
//  player_dead      in   1  level-sensitive; sampled in PLAY only
//  level_done       in   1  level-sensitive; sampled in PLAY only
//  start_btn        in   1  debounced, synchronised restart request
//  game_over_text   in   1  pixel mask from text renderer
//  win_text         in   1  pixel mask
//  level_text       in   1  pixel mask ("LEVEL")
//  level_num1_text  in   1  pixel mask ("1")
//  level_num2_text  in   1  pixel mask ("2")
//  game_active      out  1  1 only in PLAY; enables player movement
//  level_idx        out  1  current level, 0-based (width clog2(NUM_LEVELS), min 1)
//  text_sel         out  2  00 none, 01 level banner, 10 win, 11 game over
//  text_on          out  1  registered: current pixel belongs to the visible overlay
//  blink            out  1  blink phase; 1 = end-screen text visible
// BEHAVIOUR
//  States: BANNER, PLAY, WIN, OVER. Reset -> BANNER, level_idx=0, frame counter=0,
//   blink=1, game_active=0, text_on=0, text_sel=01. Reset mid-game takes effect in one clk.
//  BANNER: count frame_tick; on tick that brings count to BANNER_FRAMES -> PLAY.
//  PLAY: player_dead -> OVER. level_done -> WIN if level_idx==NUM_LEVELS-1, else
//   level_idx+1 and -> BANNER. If both fire in the same clk, player_dead wins (-> OVER).
//  WIN/OVER: count frame_tick up to END_HOLD_FRAMES (saturate); blink toggles every
//   BLINK_FRAMES ticks, starting at 1 on entry. start_btn while count<END_HOLD_FRAMES
//   is ignored; when count==END_HOLD_FRAMES, start_btn -> BANNER, level_idx=0.
//  Every state transition clears the frame and blink counters in the same clk. A
//   frame_tick coincident with a transition is consumed by the transition, not counted.
//  Inputs other than frame_tick and start_btn are ignored outside their listed state.
//  game_active and text_sel are decoded from the registered state (0-cycle after state).
//  text_on latency is 1 clk from the mask inputs:
//   BANNER: level_text | (level_idx==0 ? level_num1_text : level_num2_text)
//   WIN: win_text & blink;  OVER: game_over_text & blink;  PLAY: 0.
//  Counters sized clog2(max(BANNER_FRAMES,END_HOLD_FRAMES)+1); no wrap, saturation only.
// STRUCTURE
//  Shared package: state encoding, TEXT_SEL_* codes, frame-count width function.
//  One sub-module: frame_timer (tick-driven up-counter with synchronous clear,
//   saturate at limit, done flag); used for banner/hold timing. Blink counter inline.
// TESTING
//  Reset, 120 frame_ticks -> game_active rises exactly on the 120th tick +1 clk; text_sel=01 before.
//  PLAY lvl0, level_done pulse -> level_idx=1, BANNER; text_on follows level_num2_text only.
//  PLAY lvl1, level_done -> WIN, text_sel=10; blink toggles at ticks 30,60,90; text_on=win_text&blink.
//  PLAY, player_dead and level_done in same clk -> OVER, level_idx unchanged, game_active=0 next clk.
//  OVER, start_btn at tick 179 -> ignored; start_btn at tick 180 -> BANNER, level_idx=0.
//  Assert rst in WIN mid-blink -> next clk BANNER, blink=1, text_on=0, counters 0.

Source files
------------

// File: rtl/overlay_sequencer_pkg.sv
// Shared definitions for the text-overlay game-flow sequencer: state encoding,
// text layer select codes and frame counter sizing.
package overlay_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BANNER = 2'd0,
        ST_PLAY   = 2'd1,
        ST_WIN    = 2'd2,
        ST_OVER   = 2'd3
    } seq_state_t;

    localparam logic [1:0] TEXT_SEL_NONE   = 2'b00;
    localparam logic [1:0] TEXT_SEL_BANNER = 2'b01;
    localparam logic [1:0] TEXT_SEL_WIN    = 2'b10;
    localparam logic [1:0] TEXT_SEL_OVER   = 2'b11;

    // Wide enough to hold the larger of the two frame limits without wrapping.
    function automatic int frame_count_width(input int banner_frames, input int hold_frames);
        int max_frames;
        int width;
        max_frames = (banner_frames > hold_frames) ? banner_frames : hold_frames;
        width = $clog2(max_frames + 1);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/overlay_sequencer_frame_timer.sv
// Frame-tick up-counter with synchronous clear that saturates at a runtime limit.
// Used for both the banner hold and the end-screen minimum hold.
module overlay_sequencer_frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick && (count < limit)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/overlay_sequencer.sv
// Game-flow controller for the on-screen text overlay: picks the visible text layer,
// gates maze play, tracks the level index and blinks end-of-game text.
//
//   state  | meaning
//   BANNER | "LEVEL n" shown, waiting BANNER_FRAMES frames
//   PLAY   | maze live, watching death / goal events
//   WIN    | final level cleared, blinking WIN!, restart after hold
//   OVER   | player died, blinking GAME OVER, restart after hold
module overlay_sequencer
    import overlay_sequencer_pkg::*;
#(
    parameter int BANNER_FRAMES   = 120,
    parameter int BLINK_FRAMES    = 30,
    parameter int END_HOLD_FRAMES = 180,
    parameter int NUM_LEVELS      = 2,
    localparam int LVL_W          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             player_dead,
    input  logic             level_done,
    input  logic             start_btn,
    input  logic             game_over_text,
    input  logic             win_text,
    input  logic             level_text,
    input  logic             level_num1_text,
    input  logic             level_num2_text,
    output logic             game_active,
    output logic [LVL_W-1:0] level_idx,
    output logic [1:0]       text_sel,
    output logic             text_on,
    output logic             blink
);

    localparam int CNT_W   = frame_count_width(BANNER_FRAMES, END_HOLD_FRAMES);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    seq_state_t         state;
    seq_state_t         state_next;
    logic [LVL_W-1:0]   level_next;
    logic               leave;
    logic [CNT_W-1:0]   timer_limit;
    logic [CNT_W-1:0]   frame_count;
    logic               hold_done;
    logic               timer_tick;
    logic [BLINK_W-1:0] blink_cnt;
    logic               end_screen;

    assign end_screen = (state == ST_WIN) || (state == ST_OVER);
    assign timer_limit = (state == ST_BANNER) ? CNT_W'(BANNER_FRAMES) : CNT_W'(END_HOLD_FRAMES);
    // The timer idles in PLAY; it is cleared on the way in and out anyway.
    assign timer_tick = frame_tick && (state != ST_PLAY);

    always_comb begin
        state_next = state;
        level_next = level_idx;
        case (state)
            ST_BANNER: begin
                if (frame_tick && (frame_count == CNT_W'(BANNER_FRAMES - 1))) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (player_dead) begin
                    state_next = ST_OVER;
                end else if (level_done) begin
                    if (level_idx == LVL_W'(NUM_LEVELS - 1)) begin
                        state_next = ST_WIN;
                    end else begin
                        state_next = ST_BANNER;
                        level_next = level_idx + LVL_W'(1);
                    end
                end
            end
            ST_WIN, ST_OVER: begin
                if (start_btn && hold_done) begin
                    state_next = ST_BANNER;
                    level_next = '0;
                end
            end
            default: begin
                state_next = ST_BANNER;
                level_next = '0;
            end
        endcase
        leave = (state_next != state);
    end

    overlay_sequencer_frame_timer #(
        .WIDTH(CNT_W)
    ) u_frame_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (leave),
        .tick  (timer_tick),
        .limit (timer_limit),
        .count (frame_count),
        .done  (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BANNER;
            level_idx <= '0;
            blink     <= 1'b1;
            blink_cnt <= '0;
            text_on   <= 1'b0;
        end else begin
            state     <= state_next;
            level_idx <= level_next;

            // A tick landing on a transition clk is swallowed by the transition.
            if (leave) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (end_screen && frame_tick) begin
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end

            case (state)
                ST_BANNER: text_on <= level_text |
                                      ((level_idx == '0) ? level_num1_text : level_num2_text);
                ST_WIN:    text_on <= win_text & blink;
                ST_OVER:   text_on <= game_over_text & blink;
                default:   text_on <= 1'b0;
            endcase
        end
    end

    assign game_active = (state == ST_PLAY);

    always_comb begin
        case (state)
            ST_BANNER: text_sel = TEXT_SEL_BANNER;
            ST_WIN:    text_sel = TEXT_SEL_WIN;
            ST_OVER:   text_sel = TEXT_SEL_OVER;
            default:   text_sel = TEXT_SEL_NONE;
        endcase
    end

endmodule

// File: tb/tb_overlay_sequencer.sv
// Directed bench for overlay_sequencer: walks a full game (banner, both levels,
// win, reset, death, restart) checking outputs against hand-computed values.
module tb_overlay_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       player_dead;
    logic       level_done;
    logic       start_btn;
    logic       game_over_text;
    logic       win_text;
    logic       level_text;
    logic       level_num1_text;
    logic       level_num2_text;
    logic       game_active;
    logic [0:0] level_idx;
    logic [1:0] text_sel;
    logic       text_on;
    logic       blink;

    int tests_run;
    int tests_failed;

    overlay_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .player_dead     (player_dead),
        .level_done      (level_done),
        .start_btn       (start_btn),
        .game_over_text  (game_over_text),
        .win_text        (win_text),
        .level_text      (level_text),
        .level_num1_text (level_num1_text),
        .level_num2_text (level_num2_text),
        .game_active     (game_active),
        .level_idx       (level_idx),
        .text_sel        (text_sel),
        .text_on         (text_on),
        .blink           (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each tick is a one-clk pulse followed by one idle clk.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic masks(input logic lt, input logic n1, input logic n2, input logic wt, input logic go);
        level_text      = lt;
        level_num1_text = n1;
        level_num2_text = n2;
        win_text        = wt;
        game_over_text  = go;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        frame_tick   = 1'b0;
        player_dead  = 1'b0;
        level_done   = 1'b0;
        start_btn    = 1'b0;
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        step();
        step();
        rst = 1'b0;

        check("reset_game_active", 32'(game_active), 32'd0);
        check("reset_text_sel", 32'(text_sel), 32'd1);
        check("reset_level_idx", 32'(level_idx), 32'd0);
        check("reset_blink", 32'(blink), 32'd1);
        check("reset_text_on", 32'(text_on), 32'd0);

        // Level 0 banner: death/goal ignored, only "1" digit visible
        player_dead = 1'b1;
        level_done  = 1'b1;
        step();
        player_dead = 1'b0;
        level_done  = 1'b0;
        check("banner_ignores_events", 32'(text_sel), 32'd1);
        ticks(119);
        check("banner_119_inactive", 32'(game_active), 32'd0);
        check("banner_119_text_sel", 32'(text_sel), 32'd1);
        masks(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("banner_lvl0_num1", 32'(text_on), 32'd1);
        masks(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("banner_lvl0_num2_hidden", 32'(text_on), 32'd0);
        masks(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("banner_level_text", 32'(text_on), 32'd1);
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        frame_tick = 1'b1;
        check("banner_tick120_before_edge", 32'(game_active), 32'd0);
        step();
        frame_tick = 1'b0;
        check("banner_tick120_active", 32'(game_active), 32'd1);
        check("play_text_sel", 32'(text_sel), 32'd0);

        masks(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("play_text_off", 32'(text_on), 32'd0);
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Level 0 done -> level 1 banner, only "2" digit visible
        level_done = 1'b1;
        step();
        level_done = 1'b0;
        check("lvl0_done_level_idx", 32'(level_idx), 32'd1);
        check("lvl0_done_text_sel", 32'(text_sel), 32'd1);
        check("lvl0_done_inactive", 32'(game_active), 32'd0);
        masks(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("banner_lvl1_num1_hidden", 32'(text_on), 32'd0);
        masks(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("banner_lvl1_num2", 32'(text_on), 32'd1);
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        ticks(120);
        check("lvl1_play", 32'(game_active), 32'd1);

        // Level 1 done -> WIN with blinking text
        level_done = 1'b1;
        step();
        level_done = 1'b0;
        check("win_text_sel", 32'(text_sel), 32'd2);
        check("win_level_idx", 32'(level_idx), 32'd1);
        check("win_blink_entry", 32'(blink), 32'd1);
        masks(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("win_text_on_visible", 32'(text_on), 32'd1);
        ticks(29);
        check("win_blink_tick29", 32'(blink), 32'd1);
        ticks(1);
        check("win_blink_tick30", 32'(blink), 32'd0);
        check("win_text_on_hidden", 32'(text_on), 32'd0);
        ticks(30);
        check("win_blink_tick60", 32'(blink), 32'd1);
        check("win_text_on_tick60", 32'(text_on), 32'd1);
        ticks(30);
        check("win_blink_tick90", 32'(blink), 32'd0);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check("win_early_start_ignored", 32'(text_sel), 32'd2);

        // Reset mid-blink
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_win_text_sel", 32'(text_sel), 32'd1);
        check("rst_win_blink", 32'(blink), 32'd1);
        check("rst_win_text_on", 32'(text_on), 32'd0);
        check("rst_win_level_idx", 32'(level_idx), 32'd0);
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(119);
        check("rst_banner_count_cleared", 32'(game_active), 32'd0);
        ticks(1);
        check("rst_banner_to_play", 32'(game_active), 32'd1);

        // Advance to level 1, then death and goal together -> OVER
        level_done = 1'b1;
        step();
        level_done = 1'b0;
        ticks(120);
        check("lvl1_play_again", 32'(game_active), 32'd1);
        player_dead = 1'b1;
        level_done  = 1'b1;
        step();
        player_dead = 1'b0;
        level_done  = 1'b0;
        check("dead_wins_text_sel", 32'(text_sel), 32'd3);
        check("dead_level_unchanged", 32'(level_idx), 32'd1);
        check("dead_inactive", 32'(game_active), 32'd0);
        masks(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("over_text_on", 32'(text_on), 32'd1);

        ticks(179);
        check("over_blink_tick179", 32'(blink), 32'd0);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check("over_start_179_ignored", 32'(text_sel), 32'd3);
        ticks(1);
        check("over_blink_tick180", 32'(blink), 32'd1);
        check("over_still_over", 32'(text_sel), 32'd3);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check("over_restart_text_sel", 32'(text_sel), 32'd1);
        check("over_restart_level_idx", 32'(level_idx), 32'd0);
        check("over_restart_blink", 32'(blink), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
